// File: rtl/stopwatch_sequencer.sv
// Stopwatch timebase: decodes the one-hot mode levels, prescales the clock into
// count ticks, advances a packed-BCD count by 1 or 10, and keeps a lap snapshot.
module stopwatch_sequencer #(
  parameter int PRESCALE = 100,
  parameter int DIGITS   = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                one_run_push,
  input  logic                ten_run_push,
  input  logic                pause_push,
  input  logic                clear_push,
  input  logic                lap,
  output logic [4*DIGITS-1:0] count,
  output logic [4*DIGITS-1:0] display,
  output logic                tick,
  output logic                wrap,
  output logic                running,
  output logic                lap_active
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  logic [3:0]    mode_s;
  logic          mode_one_s;
  logic          mode_ten_s;
  logic          mode_pause_s;
  logic          mode_clear_s;
  logic          mode_legal_s;

  logic [PW-1:0] presc_q, presc_d;
  logic [W-1:0]  count_q, count_d;
  logic [W-1:0]  snap_q, snap_d;
  logic          lap_active_q, lap_active_d;
  logic          tick_q, tick_d;
  logic          wrap_q, wrap_d;

  logic [W-1:0]  inc_val_s;
  logic          inc_carry_s;
  logic [3:0]    digit_s;
  logic          carry_s;

  assign mode_s = {clear_push, pause_push, ten_run_push, one_run_push};

  // Anything other than exactly one mode level decodes to nothing, i.e. a full hold.
  always_comb begin
    mode_one_s   = 1'b0;
    mode_ten_s   = 1'b0;
    mode_pause_s = 1'b0;
    mode_clear_s = 1'b0;
    case (mode_s)
      4'b0001: mode_one_s   = 1'b1;
      4'b0010: mode_ten_s   = 1'b1;
      4'b0100: mode_pause_s = 1'b1;
      4'b1000: mode_clear_s = 1'b1;
      default: mode_pause_s = 1'b0;
    endcase
  end

  assign mode_legal_s = mode_one_s | mode_ten_s | mode_pause_s;
  assign running      = mode_one_s | mode_ten_s;

  always_comb begin
    inc_val_s = count_q;
    carry_s   = 1'b1;
    digit_s   = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      digit_s = count_q[4*i +: 4];
      if ((carry_s == 1'b1) && ((i > 0) || !mode_ten_s)) begin
        if (digit_s == 4'd9) begin
          inc_val_s[4*i +: 4] = 4'd0;
        end else begin
          inc_val_s[4*i +: 4] = digit_s + 4'd1;
          carry_s             = 1'b0;
        end
      end else begin
        inc_val_s[4*i +: 4] = digit_s;
      end
    end
    inc_carry_s = carry_s;
  end

  always_comb begin
    presc_d      = presc_q;
    count_d      = count_q;
    snap_d       = snap_q;
    lap_active_d = lap_active_q;
    tick_d       = 1'b0;
    wrap_d       = 1'b0;

    if (mode_clear_s) begin
      presc_d      = {PW{1'b0}};
      count_d      = {W{1'b0}};
      lap_active_d = 1'b0;
    end else if (running) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = {PW{1'b0}};
        count_d = inc_val_s;
        tick_d  = 1'b1;
        wrap_d  = inc_carry_s;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end else begin
      presc_d = presc_q;
    end

    // Snapshot takes count_q, so a lap on a tick edge freezes the pre-increment value.
    if (lap && mode_legal_s) begin
      if (lap_active_q) begin
        lap_active_d = 1'b0;
      end else if (running) begin
        snap_d       = count_q;
        lap_active_d = 1'b1;
      end else begin
        lap_active_d = lap_active_q;
      end
    end else begin
      snap_d = snap_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      presc_q      <= {PW{1'b0}};
      count_q      <= {W{1'b0}};
      snap_q       <= {W{1'b0}};
      lap_active_q <= 1'b0;
      tick_q       <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      count_q      <= count_d;
      snap_q       <= snap_d;
      lap_active_q <= lap_active_d;
      tick_q       <= tick_d;
      wrap_q       <= wrap_d;
    end
  end

  assign count      = count_q;
  assign display    = lap_active_q ? snap_q : count_q;
  assign tick       = tick_q;
  assign wrap       = wrap_q;
  assign lap_active = lap_active_q;

endmodule

// File: tb/tb_stopwatch_sequencer.sv
// Directed bench for stopwatch_sequencer with PRESCALE=4, DIGITS=4.
module tb_stopwatch_sequencer;

  logic        clk = 1'b0;
  logic        n_rst = 1'b1;
  logic        one_run_push = 1'b0;
  logic        ten_run_push = 1'b0;
  logic        pause_push = 1'b0;
  logic        clear_push = 1'b0;
  logic        lap = 1'b0;
  logic [15:0] count;
  logic [15:0] display;
  logic        tick;
  logic        wrap;
  logic        running;
  logic        lap_active;

  int tests_run = 0;
  int tests_failed = 0;

  stopwatch_sequencer #(.PRESCALE(4), .DIGITS(4)) dut (
    .clk(clk), .n_rst(n_rst),
    .one_run_push(one_run_push), .ten_run_push(ten_run_push),
    .pause_push(pause_push), .clear_push(clear_push), .lap(lap),
    .count(count), .display(display), .tick(tick), .wrap(wrap),
    .running(running), .lap_active(lap_active)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    to_bcd = {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mode(input logic one, input logic ten, input logic pau, input logic clr);
    one_run_push = one;
    ten_run_push = ten;
    pause_push   = pau;
    clear_push   = clr;
  endtask

  task automatic do_reset();
    set_mode(1'b0, 1'b0, 1'b1, 1'b0);
    lap   = 1'b0;
    n_rst = 1'b0;
    edge_step();
    n_rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++; if (count !== 16'h0000) begin tests_failed++; $display("FAIL reset_count got %h want %h", count, 16'h0000); end
    tests_run++; if (display !== 16'h0000) begin tests_failed++; $display("FAIL reset_display got %h want %h", display, 16'h0000); end
    tests_run++; if ({tick, wrap, lap_active} !== 3'b000) begin tests_failed++; $display("FAIL reset_flags got %b want %b", {tick, wrap, lap_active}, 3'b000); end
    tests_run++; if (running !== 1'b0) begin tests_failed++; $display("FAIL reset_running_pause got %b want 0", running); end
    set_mode(1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    tests_run++; if (running !== 1'b1) begin tests_failed++; $display("FAIL running_comb got %b want 1", running); end
    set_mode(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_one_run();
    do_reset();
    set_mode(1'b1, 1'b0, 1'b0, 1'b0);
    for (int e = 1; e <= 40; e++) begin
      edge_step();
      tests_run++; if (tick !== ((e % 4) == 0)) begin tests_failed++; $display("FAIL one_tick edge %0d got %b want %b", e, tick, (e % 4) == 0); end
      tests_run++; if (wrap !== 1'b0) begin tests_failed++; $display("FAIL one_wrap edge %0d got %b want 0", e, wrap); end
    end
    tests_run++; if (count !== 16'h0010) begin tests_failed++; $display("FAIL one_count got %h want %h", count, 16'h0010); end
  endtask

  task automatic test_ten_wrap();
    do_reset();
    set_mode(1'b0, 1'b1, 1'b0, 1'b0);
    for (int e = 1; e <= 4000; e++) begin
      edge_step();
      tests_run++; if (count !== to_bcd(((e / 4) * 10) % 10000)) begin tests_failed++; $display("FAIL ten_count edge %0d got %h want %h", e, count, to_bcd(((e / 4) * 10) % 10000)); end
      tests_run++; if (wrap !== (e == 4000)) begin tests_failed++; $display("FAIL ten_wrap edge %0d got %b want %b", e, wrap, e == 4000); end
      tests_run++; if (tick !== ((e % 4) == 0)) begin tests_failed++; $display("FAIL ten_tick edge %0d got %b want %b", e, tick, (e % 4) == 0); end
    end
    edge_step();
    tests_run++; if ({tick, wrap} !== 2'b00) begin tests_failed++; $display("FAIL ten_wrap_pulse got %b want %b", {tick, wrap}, 2'b00); end
  endtask

  task automatic test_pause_phase();
    do_reset();
    set_mode(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (10) edge_step();
    tests_run++; if (count !== 16'h0002) begin tests_failed++; $display("FAIL pause_pre_count got %h want %h", count, 16'h0002); end
    set_mode(1'b0, 1'b0, 1'b1, 1'b0);
    for (int e = 1; e <= 20; e++) begin
      edge_step();
      tests_run++; if ({tick, count} !== {1'b0, 16'h0002}) begin tests_failed++; $display("FAIL pause_hold edge %0d got %b/%h want 0/0002", e, tick, count); end
    end
    set_mode(1'b1, 1'b0, 1'b0, 1'b0);
    edge_step();
    tests_run++; if (tick !== 1'b0) begin tests_failed++; $display("FAIL resume_edge1_tick got %b want 0", tick); end
    edge_step();
    tests_run++; if ({tick, count} !== {1'b1, 16'h0003}) begin tests_failed++; $display("FAIL resume_edge2 got %b/%h want 1/0003", tick, count); end
    // ONE to TEN mid-period keeps phase: two ONE edges then two TEN edges ticks by ten.
    edge_step(); edge_step();
    set_mode(1'b0, 1'b1, 1'b0, 1'b0);
    edge_step();
    tests_run++; if (tick !== 1'b0) begin tests_failed++; $display("FAIL switch_early_tick got %b want 0", tick); end
    edge_step();
    tests_run++; if ({tick, count} !== {1'b1, 16'h0013}) begin tests_failed++; $display("FAIL switch_keep_phase got %b/%h want 1/0013", tick, count); end
  endtask

  task automatic test_lap();
    do_reset();
    set_mode(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (20) edge_step();
    tests_run++; if (count !== 16'h0005) begin tests_failed++; $display("FAIL lap_pre_count got %h want %h", count, 16'h0005); end
    lap = 1'b1; edge_step(); lap = 1'b0;
    tests_run++; if ({lap_active, display} !== {1'b1, 16'h0005}) begin tests_failed++; $display("FAIL lap_freeze got %b/%h want 1/0005", lap_active, display); end
    repeat (11) edge_step();
    tests_run++; if (count !== 16'h0008) begin tests_failed++; $display("FAIL lap_live_count got %h want %h", count, 16'h0008); end
    tests_run++; if (display !== 16'h0005) begin tests_failed++; $display("FAIL lap_held_display got %h want %h", display, 16'h0005); end
    lap = 1'b1; edge_step(); lap = 1'b0;
    tests_run++; if ({lap_active, display} !== {1'b0, 16'h0008}) begin tests_failed++; $display("FAIL lap_release got %b/%h want 0/0008", lap_active, display); end
    edge_step(); edge_step();
    lap = 1'b1; edge_step(); lap = 1'b0;
    tests_run++; if ({tick, count} !== {1'b1, 16'h0009}) begin tests_failed++; $display("FAIL lap_tick_count got %b/%h want 1/0009", tick, count); end
    tests_run++; if ({lap_active, display} !== {1'b1, 16'h0008}) begin tests_failed++; $display("FAIL lap_tick_snapshot got %b/%h want 1/0008", lap_active, display); end
  endtask

  task automatic test_clear_illegal();
    do_reset();
    set_mode(1'b1, 1'b0, 1'b0, 1'b0);
    for (int e = 1; e <= 148; e++) begin
      lap = (e == 10);
      edge_step();
    end
    lap = 1'b0;
    tests_run++; if ({lap_active, count, display} !== {1'b1, 16'h0037, 16'h0002}) begin tests_failed++; $display("FAIL clear_pre got %b/%h/%h want 1/0037/0002", lap_active, count, display); end
    set_mode(1'b0, 1'b0, 1'b0, 1'b1);
    lap = 1'b1; edge_step(); lap = 1'b0;
    tests_run++; if ({lap_active, tick, count, display} !== {2'b00, 16'h0000, 16'h0000}) begin tests_failed++; $display("FAIL clear_result got %b%b/%h/%h want 00/0000/0000", lap_active, tick, count, display); end
    set_mode(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (8) edge_step();
    tests_run++; if (count !== 16'h0002) begin tests_failed++; $display("FAIL clear_presc_zero got %h want %h", count, 16'h0002); end
    set_mode(1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    tests_run++; if (running !== 1'b0) begin tests_failed++; $display("FAIL illegal_running got %b want 0", running); end
    for (int e = 1; e <= 12; e++) begin
      lap = (e == 5);
      edge_step();
      tests_run++; if ({tick, lap_active, count} !== {2'b00, 16'h0002}) begin tests_failed++; $display("FAIL illegal_hold edge %0d got %b%b/%h want 00/0002", e, tick, lap_active, count); end
    end
    lap = 1'b0;
    set_mode(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) edge_step();
    tests_run++; if (tick !== 1'b0) begin tests_failed++; $display("FAIL illegal_resume_early got %b want 0", tick); end
    edge_step();
    tests_run++; if ({tick, count} !== {1'b1, 16'h0003}) begin tests_failed++; $display("FAIL illegal_resume got %b/%h want 1/0003", tick, count); end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    set_mode(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (495) edge_step();
    tests_run++; if (count !== 16'h0123) begin tests_failed++; $display("FAIL mid_pre_count got %h want %h", count, 16'h0123); end
    n_rst = 1'b0; lap = 1'b1;
    edge_step();
    n_rst = 1'b1; lap = 1'b0;
    tests_run++; if ({count, display, tick, wrap, lap_active} !== {32'h0, 3'b000}) begin tests_failed++; $display("FAIL mid_reset got %h/%h/%b%b%b want 0000/0000/000", count, display, tick, wrap, lap_active); end
    for (int e = 1; e <= 4; e++) begin
      edge_step();
      tests_run++; if (tick !== (e == 4)) begin tests_failed++; $display("FAIL mid_first_tick edge %0d got %b want %b", e, tick, e == 4); end
    end
    tests_run++; if (count !== 16'h0001) begin tests_failed++; $display("FAIL mid_post_count got %h want %h", count, 16'h0001); end
  endtask

  initial begin
    test_reset();
    test_one_run();
    test_ten_wrap();
    test_pause_phase();
    test_lap();
    test_clear_illegal();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
